// File: rtl/text_glyph_sequencer_pkg.sv
// Shared video timing constants and FSM encoding for the text-mode glyph sequencer.
package text_glyph_sequencer_pkg;

  localparam int COLS      = 64;
  localparam int TEXT_ROWS = 30;
  localparam int GLYPH_W   = 10;
  localparam int GLYPH_H   = 16;
  localparam int ADDR_W    = 11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_CHAR,
    ST_GLYPH,
    ST_READY,
    ST_RUN,
    ST_DEAD
  } state_t;

endpackage

// File: rtl/text_glyph_sequencer_glyph_shift_reg.sv
// Glyph row shifter (LSB = next pixel) with a one-deep prefetch buffer for the next character.
module glyph_shift_reg
  import text_glyph_sequencer_pkg::*;
#(
  parameter int WIDTH = GLYPH_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             pre_load,
  input  logic             swap,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             lsb
);

  logic [WIDTH-1:0] shifter;
  logic [WIDTH-1:0] prefetch;

  // swap wins over shift: the last bit leaves through lsb while the next glyph lands
  always_ff @(posedge clk) begin
    if (rst) begin
      shifter  <= '0;
      prefetch <= '0;
    end else begin
      if (load)
        shifter <= din;
      else if (swap)
        shifter <= prefetch;
      else if (shift)
        shifter <= shifter >> 1;
      if (pre_load)
        prefetch <= din;
    end
  end

  assign lsb = shifter[0];

endmodule

// File: rtl/text_glyph_sequencer.sv
// Text-mode pixel sequencer: fetches character codes and glyph rows, serialises pixels per line.
module text_glyph_sequencer
  import text_glyph_sequencer_pkg::*;
#(
  parameter int COLS      = text_glyph_sequencer_pkg::COLS,
  parameter int TEXT_ROWS = text_glyph_sequencer_pkg::TEXT_ROWS,
  parameter int GLYPH_W   = text_glyph_sequencer_pkg::GLYPH_W,
  parameter int GLYPH_H   = text_glyph_sequencer_pkg::GLYPH_H,
  parameter int ADDR_W    = text_glyph_sequencer_pkg::ADDR_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       frame_start,
  input  logic                       line_start,
  input  logic                       active,
  output logic [ADDR_W-1:0]          tb_addr,
  input  logic [7:0]                 tb_data,
  output logic [7:0]                 font_char,
  output logic [$clog2(GLYPH_H)-1:0] font_row,
  input  logic [GLYPH_W-1:0]         font_data,
  output logic                       pixel,
  output logic                       pixel_valid,
  output logic                       underrun
);

  localparam int GROW_W = $clog2(GLYPH_H);
  localparam int TROW_W = $clog2(TEXT_ROWS);
  localparam int COL_W  = $clog2(COLS);
  localparam int CNT_W  = $clog2(GLYPH_W);

  state_t              state;
  logic [COL_W-1:0]    col;
  logic [CNT_W-1:0]    cnt;
  logic [GROW_W-1:0]   glyph_row;
  logic [TROW_W-1:0]   text_row;
  logic                active_q;
  logic                rise, last_bit, last_col, line_end;
  logic                sh_load, sh_pre_load, sh_swap, sh_shift, sh_lsb;

  function automatic logic [ADDR_W-1:0] row_addr(input logic [TROW_W-1:0] trow,
                                                 input logic [COL_W-1:0]  c);
    return ADDR_W'(int'(trow) * COLS + int'(c));
  endfunction

  // cnt is the index of the pixel emitted at the coming edge
  always_comb begin
    rise        = active && !active_q;
    last_bit    = (cnt == CNT_W'(GLYPH_W - 1));
    last_col    = (col == COL_W'(COLS - 1));
    sh_load     = (state == ST_GLYPH);
    sh_shift    = active && (state == ST_READY || state == ST_RUN);
    sh_pre_load = (state == ST_RUN) && active && !last_col && (cnt == CNT_W'(3));
    sh_swap     = (state == ST_RUN) && active && last_bit && !last_col;
    line_end    = ((state == ST_RUN) && (!active || (last_bit && last_col))) ||
                  ((state == ST_DEAD) && !active);
  end

  glyph_shift_reg #(.WIDTH(GLYPH_W)) u_shift (
    .clk      (clk),
    .rst      (rst),
    .load     (sh_load),
    .pre_load (sh_pre_load),
    .swap     (sh_swap),
    .shift    (sh_shift),
    .din      (font_data),
    .lsb      (sh_lsb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      tb_addr     <= '0;
      font_char   <= '0;
      font_row    <= '0;
      pixel       <= 1'b0;
      pixel_valid <= 1'b0;
      underrun    <= 1'b0;
      col         <= '0;
      cnt         <= '0;
      active_q    <= 1'b0;
    end else begin
      active_q    <= active;
      pixel       <= 1'b0;
      pixel_valid <= 1'b0;
      case (state)
        ST_IDLE, ST_ADDR, ST_CHAR, ST_GLYPH: begin
          if (rise) begin
            underrun <= 1'b1;
            state    <= ST_DEAD;
          end else begin
            case (state)
              ST_IDLE: if (line_start) begin
                tb_addr <= row_addr(text_row, '0);
                col     <= '0;
                cnt     <= '0;
                state   <= ST_ADDR;
              end
              ST_ADDR: state <= ST_CHAR;
              ST_CHAR: begin
                font_char <= tb_data;
                font_row  <= glyph_row;
                state     <= ST_GLYPH;
              end
              default: state <= ST_READY;
            endcase
          end
        end
        ST_READY: if (active) begin
          pixel       <= sh_lsb;
          pixel_valid <= 1'b1;
          cnt         <= CNT_W'(1);
          state       <= ST_RUN;
          if (!last_col)
            tb_addr <= row_addr(text_row, col + 1'b1);
        end
        ST_RUN: begin
          if (!active) begin
            state <= ST_IDLE;
          end else begin
            pixel       <= sh_lsb;
            pixel_valid <= 1'b1;
            // background fetch of the next column rides on the pixel count
            if (cnt == '0 && !last_col)
              tb_addr <= row_addr(text_row, col + 1'b1);
            if (cnt == CNT_W'(2) && !last_col) begin
              font_char <= tb_data;
              font_row  <= glyph_row;
            end
            if (last_bit) begin
              cnt <= '0;
              if (last_col)
                state <= ST_IDLE;
              else
                col <= col + 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_DEAD: if (!active) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // frame start overrides a line end landing on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      glyph_row <= '0;
      text_row  <= '0;
    end else if (frame_start) begin
      glyph_row <= '0;
      text_row  <= '0;
    end else if (line_end) begin
      if (glyph_row == GROW_W'(GLYPH_H - 1)) begin
        glyph_row <= '0;
        text_row  <= (text_row == TROW_W'(TEXT_ROWS - 1)) ? '0 : text_row + 1'b1;
      end else begin
        glyph_row <= glyph_row + 1'b1;
      end
    end
  end

endmodule

// File: doc/text_glyph_sequencer.md
TEXT_GLYPH_SEQUENCER -- requirements
Module: text_glyph_sequencer

Interface
REQ-001 Parameter: COLS, 64, text columns per line.
REQ-002 Parameter: TEXT_ROWS, 30, text rows per frame.
REQ-003 Parameter: GLYPH_W, 10, pixels per glyph row (font ROM row width).
REQ-004 Parameter: GLYPH_H, 16, glyph rows per character cell.
REQ-005 CLK  input  1  sole clock; all state changes on rising edge.
REQ-006 RST  input  1  synchronous, active-high reset.
REQ-007 FRAME_START  input  1  one-cycle pulse at start of vertical blank end (before first active line).
REQ-008 LINE_START  input  1  one-cycle pulse in horizontal blank, at least 4 cycles before ACTIVE rises.
REQ-009 ACTIVE  input  1  high for exactly COLS*GLYPH_W cycles per active line.
REQ-010 TB_ADDR  output  11  text buffer address = text_row*COLS + col.
REQ-011 TB_DATA  input  8  character code, valid 1 cycle after TB_ADDR.
REQ-012 FONT_CHAR  output  8  character code to font ROM bank.
REQ-013 FONT_ROW  output  4  glyph row to font ROM bank.
REQ-014 FONT_DATA  input  10  glyph row, bit 0 = leftmost pixel, valid 1 cycle after FONT_CHAR/FONT_ROW (ROM samples on falling edge).
REQ-015 PIXEL  output  1  serial pixel, leftmost first.
REQ-016 PIXEL_VALID  output  1  high while PIXEL is an active pixel.
REQ-017 UNDERRUN  output  1  sticky error flag.

Function
REQ-018 FSM states: IDLE, ADDR, CHAR, GLYPH, READY, RUN, DEAD.
REQ-019 IDLE -> ADDR on LINE_START; ADDR drives TB_ADDR for col 0; CHAR registers TB_DATA onto FONT_CHAR with FONT_ROW = glyph_row; GLYPH loads FONT_DATA into shifter; -> READY.
REQ-020 READY -> RUN on ACTIVE; PIXEL = shifter bit 0 in first ACTIVE cycle, PIXEL_VALID = 1.
REQ-021 RUN: pixel counter 0..GLYPH_W-1; at count 0 issue fetch for col+1 (ADDR/CHAR/GLYPH sequence in background), result held in prefetch buffer by count 3.
REQ-022 At count GLYPH_W-1 the prefetch buffer transfers into shifter; next cycle emits its bit 0 with no gap.
REQ-023 No background fetch issued after col COLS-1; after its last pixel FSM -> IDLE, PIXEL_VALID = 0 the next cycle.
REQ-024 Line end increments glyph_row; glyph_row GLYPH_H-1 wraps to 0 and increments text_row; text_row TEXT_ROWS-1 wraps to 0.
REQ-025 FRAME_START clears glyph_row and text_row; if coincident with line end, FRAME_START wins.
REQ-026 ACTIVE rising while in IDLE/ADDR/CHAR/GLYPH: set UNDERRUN, enter DEAD; DEAD drives PIXEL = 0, PIXEL_VALID = 0 until ACTIVE falls, then advances line counters as a normal line end, -> IDLE.
REQ-027 ACTIVE falling early in RUN: abort line, PIXEL_VALID = 0 next cycle, advance counters, -> IDLE.
REQ-028 LINE_START while not IDLE is ignored.
REQ-029 PIXEL = 0 whenever PIXEL_VALID = 0.

Reset
REQ-030 RST forces IDLE; TB_ADDR, FONT_CHAR, FONT_ROW, PIXEL, PIXEL_VALID, UNDERRUN, counters, shifter, prefetch buffer all 0 on the next edge.
REQ-031 RST mid-line aborts immediately; only LINE_START after RST deasserts starts a fetch.
REQ-032 UNDERRUN clears only on RST.

Structure
REQ-033 Shared video package holds COLS, TEXT_ROWS, GLYPH_W, GLYPH_H, address width and FSM state encoding.
REQ-034 One sub-module: glyph_shift_reg (GLYPH_W-bit load/shift register with prefetch buffer).

Verification
REQ-035 Reset: RST high 2 cycles mid-RUN -> all outputs 0, state IDLE next edge.
REQ-036 Line 0, text buffer col0='H'(0x48), col1=0x41, ROM row0 of 'H' = 10'b1000000001 -> PIXEL_VALID high 640 cycles, first 10 pixels 1,0,0,0,0,0,0,0,0,1, TB_ADDR 0x000 then 0x001, FONT_ROW = 0.
REQ-037 17 consecutive lines after FRAME_START -> FONT_ROW 0..15 then 0; line 17 TB_ADDR starts 0x040.
REQ-038 ACTIVE raised 2 cycles after LINE_START -> UNDERRUN = 1, PIXEL_VALID = 0 that line; next line with 4-cycle gap renders normally, UNDERRUN stays 1.
REQ-039 FRAME_START coincident with end of line 479 -> next line uses text_row 0, glyph_row 0 (TB_ADDR 0x000).
REQ-040 ACTIVE dropped after 35 pixels -> PIXEL_VALID = 0 next cycle, next line uses glyph_row + 1.
